// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: requester ids and FSM states.
// Requester ids are also what the arbiter drives on gnt_id.
package mem_arbiter_pkg;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_IF   = 2'd1;
  localparam logic [1:0] ID_LS   = 2'd2;
  localparam logic [1:0] ID_EXT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner picker for the memory arbiter.
// Ports:
//   if_req, ls_req, ext_req : pending requests
//   streak_full             : LS has won MAX_STREAK times in a row while IF waited
//   win_id                  : winning requester id (ID_NONE when nobody asks)
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       ext_req,
  input  logic       streak_full,
  output logic [1:0] win_id
);

  // EXT > LS > IF, except a starved IF is promoted above LS (never above EXT)
  always_comb begin
    win_id = ID_NONE;
    if (ext_req) begin
      win_id = ID_EXT;
    end else if (if_req && streak_full) begin
      win_id = ID_IF;
    end else if (ls_req) begin
      win_id = ID_LS;
    end else if (if_req) begin
      win_id = ID_IF;
    end else begin
      win_id = ID_NONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for instruction fetch (IF), CPU load/store (LS)
// and the external loader/debug port (EXT). One transaction in flight at a time;
// IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Every output is a register.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   if_*/ls_*/ext_*          : requester handshakes (req held until one-cycle ack)
//   rd_data, err             : result of the last completed transaction
//   busy, gnt_id             : arbiter activity and current owner
//   mem_addr/din/rd/wr       : memory command (strobes are one-cycle pulses)
//   mem_dout, mem_valid      : memory response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 12,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_ack,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [AWIDTH-1:0] ls_addr,
  input  logic [DWIDTH-1:0] ls_wdata,
  output logic              ls_ack,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [AWIDTH-1:0] ext_addr,
  input  logic [DWIDTH-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DWIDTH-1:0] rd_data,
  output logic              err,
  output logic              busy,
  output logic [1:0]        gnt_id,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_dout,
  input  logic              mem_valid
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int TMO_W    = $clog2(TIMEOUT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

  arb_state_t          state_r, state_s;
  logic [1:0]          gnt_r, gnt_s;
  logic                we_r, we_s;
  logic [AWIDTH-1:0]   addr_r, addr_s;
  logic [DWIDTH-1:0]   din_r, din_s;
  logic                mem_rd_r, mem_rd_s, mem_wr_r, mem_wr_s;
  logic                if_ack_r, if_ack_s, ls_ack_r, ls_ack_s, ext_ack_r, ext_ack_s;
  logic [DWIDTH-1:0]   rd_data_r, rd_data_s;
  logic                err_r, err_s;
  logic                busy_r, busy_s;
  logic [STREAK_W-1:0] streak_r, streak_s;
  logic [TMO_W-1:0]    tmo_r, tmo_s;
  logic [1:0]          pick_s;

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .ls_req      (ls_req),
    .ext_req     (ext_req),
    .streak_full (streak_r == STREAK_MAX),
    .win_id      (pick_s)
  );

  // Next-state and next-output logic; registers hold unless a state says otherwise
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    we_s      = we_r;
    addr_s    = addr_r;
    din_s     = din_r;
    mem_rd_s  = 1'b0;
    mem_wr_s  = 1'b0;
    if_ack_s  = 1'b0;
    ls_ack_s  = 1'b0;
    ext_ack_s = 1'b0;
    rd_data_s = rd_data_r;
    err_s     = err_r;
    busy_s    = busy_r;
    streak_s  = streak_r;
    tmo_s     = tmo_r;
    case (state_r)
      S_IDLE: begin
        if (pick_s != ID_NONE) begin
          case (pick_s)
            ID_EXT: begin
              we_s   = ext_we;
              addr_s = ext_addr;
              din_s  = ext_wdata;
            end
            ID_LS: begin
              we_s   = ls_we;
              addr_s = ls_addr;
              din_s  = ls_wdata;
            end
            default: begin
              we_s   = 1'b0;
              addr_s = if_addr;
              din_s  = '0;
            end
          endcase
          state_s  = S_ISSUE;
          gnt_s    = pick_s;
          busy_s   = 1'b1;
          tmo_s    = '0;
          // Strobe registered now so it is high for exactly the ISSUE cycle
          mem_rd_s = !we_s;
          mem_wr_s = we_s;
        end else begin
          state_s = S_IDLE;
        end
        // Streak only measures LS wins that kept a waiting IF out
        if (pick_s == ID_IF) begin
          streak_s = '0;
        end else if (!if_req) begin
          streak_s = '0;
        end else if ((pick_s == ID_LS) && (streak_r != STREAK_MAX)) begin
          streak_s = streak_r + STREAK_W'(1);
        end else begin
          streak_s = streak_r;
        end
      end
      S_ISSUE: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid || (tmo_r == TMO_LAST)) begin
          state_s   = S_DONE;
          if_ack_s  = (gnt_r == ID_IF);
          ls_ack_s  = (gnt_r == ID_LS);
          ext_ack_s = (gnt_r == ID_EXT);
          if (mem_valid) begin
            rd_data_s = we_r ? '0 : mem_dout;
            err_s     = 1'b0;
          end else begin
            rd_data_s = '0;
            err_s     = 1'b1;
          end
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        gnt_s   = ID_NONE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = S_IDLE;
        gnt_s   = ID_NONE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, latched request and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      gnt_r     <= ID_NONE;
      we_r      <= 1'b0;
      addr_r    <= '0;
      din_r     <= '0;
      mem_rd_r  <= 1'b0;
      mem_wr_r  <= 1'b0;
      if_ack_r  <= 1'b0;
      ls_ack_r  <= 1'b0;
      ext_ack_r <= 1'b0;
      rd_data_r <= '0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      streak_r  <= '0;
      tmo_r     <= '0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      din_r     <= din_s;
      mem_rd_r  <= mem_rd_s;
      mem_wr_r  <= mem_wr_s;
      if_ack_r  <= if_ack_s;
      ls_ack_r  <= ls_ack_s;
      ext_ack_r <= ext_ack_s;
      rd_data_r <= rd_data_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
      streak_r  <= streak_s;
      tmo_r     <= tmo_s;
    end
  end

  assign if_ack   = if_ack_r;
  assign ls_ack   = ls_ack_r;
  assign ext_ack  = ext_ack_r;
  assign rd_data  = rd_data_r;
  assign err      = err_r;
  assign busy     = busy_r;
  assign gnt_id   = gnt_r;
  assign mem_addr = addr_r;
  assign mem_din  = din_r;
  assign mem_rd   = mem_rd_r;
  assign mem_wr   = mem_wr_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: expected completions go into a
// scoreboard queue as requests are raised; a monitor records every ack and
// each test task pops the queue and compares against the recorded acks.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we, ext_req, ext_we;
  logic [AW-1:0] if_addr, ls_addr, ext_addr;
  logic [DW-1:0] ls_wdata, ext_wdata;
  logic          if_ack, ls_ack, ext_ack, err, busy, mem_rd, mem_wr;
  logic [DW-1:0] rd_data, mem_din;
  logic [DW-1:0] mem_dout = 16'h0000;
  logic [1:0]    gnt_id;
  logic [AW-1:0] mem_addr;
  logic          mem_valid, auto_valid = 1'b0, man_valid, mem_auto;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] marr [0:(1<<AW)-1];

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MAX_STREAK(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .rd_data(rd_data), .err(err), .busy(busy), .gnt_id(gnt_id),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  assign mem_valid = auto_valid | man_valid;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers a strobe seen in the ISSUE cycle during the next cycle
  int            resp_cnt = 0;
  logic [DW-1:0] resp_data = 16'h0000;
  always @(negedge clk) begin
    auto_valid <= (resp_cnt == 1);
    if (resp_cnt == 1) mem_dout <= resp_data;
    if (mem_auto && (mem_rd || mem_wr)) begin
      resp_cnt  <= 1;
      resp_data <= marr[mem_addr];
    end else if (resp_cnt > 0) begin
      resp_cnt <= resp_cnt - 1;
    end
  end

  // Ack / strobe monitor
  int            obs_n = 0, obs_multi = 0, wr_n = 0, rd_n = 0;
  logic [1:0]    obs_id [0:63];
  logic [1:0]    obs_gnt [0:63];
  logic [DW-1:0] obs_data [0:63];
  logic          obs_err [0:63];
  int            obs_cyc [0:63];
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_din = '0;
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_n    <= wr_n + 1;
      wr_addr <= mem_addr;
      wr_din  <= mem_din;
    end
    if (mem_rd) rd_n <= rd_n + 1;
    if (if_ack || ls_ack || ext_ack) begin
      if ((int'(if_ack) + int'(ls_ack) + int'(ext_ack)) > 1) obs_multi <= obs_multi + 1;
      if (obs_n < 64) begin
        obs_id[obs_n]   <= ext_ack ? 2'd3 : (ls_ack ? 2'd2 : 2'd1);
        obs_gnt[obs_n]  <= gnt_id;
        obs_data[obs_n] <= rd_data;
        obs_err[obs_n]  <= err;
        obs_cyc[obs_n]  <= cyc;
      end
      obs_n <= obs_n + 1;
    end
  end

  // Runs cycles, dropping each request on its ack (LS after ls_keep acks)
  task automatic serve(input int budget, input int ls_keep, output bit timed_out);
    int ls_left = ls_keep;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ext_ack) ext_req = 1'b0;
      if (if_ack) if_req = 1'b0;
      if (ls_ack) begin
        ls_left--;
        if (ls_left <= 0) ls_req = 1'b0;
      end
      if (!if_req && !ls_req && !ext_req && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_ack, ls_ack, ext_ack, err, busy, mem_rd, mem_wr} !== 7'b0)
      $display("FAIL reset_flags: got %b, expected 0000000", {if_ack, ls_ack, ext_ack, err, busy, mem_rd, mem_wr});
    else n_pass++;
    n_checks++;
    if ({rd_data, gnt_id, mem_addr, mem_din} !== '0)
      $display("FAIL reset_data: rd_data=%h gnt=%0d addr=%h din=%h, expected all 0", rd_data, gnt_id, mem_addr, mem_din);
    else n_pass++;
  endtask

  task automatic test_single_read();
    int base = obs_n;
    int t0;
    bit to;
    exp_t e;
    t0 = cyc;
    if_addr = 12'h040;
    if_req  = 1'b1;
    sb.push_back('{id: 2'd1, data: 16'hBEEF, err: 1'b0});
    serve(30, 1, to);
    n_checks++;
    if (to || (obs_n - base) != 1) $display("FAIL single_count: timeout=%0d acks=%0d, expected 0/1", to, obs_n - base);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (obs_id[base] !== e.id || obs_gnt[base] !== e.id || obs_data[base] !== e.data || obs_err[base] !== e.err)
      $display("FAIL single_ack: id=%0d gnt=%0d data=%h err=%b, expected id=%0d data=%h err=%b",
               obs_id[base], obs_gnt[base], obs_data[base], obs_err[base], e.id, e.data, e.err);
    else n_pass++;
    n_checks++;
    if (obs_cyc[base] - t0 != 3) $display("FAIL single_latency: got %0d cycles, expected 3", obs_cyc[base] - t0);
    else n_pass++;
    n_checks++;
    if (rd_data !== 16'hBEEF) $display("FAIL single_hold: rd_data=%h, expected beef", rd_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int base = obs_n;
    mem_auto = 1'b0;
    if_addr  = 12'h123;
    if_req   = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: busy=%b, expected 1", busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    if_req    = 1'b0;
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_n != base || busy !== 1'b0) $display("FAIL midrst_noack: acks=%0d busy=%b, expected 0/0", obs_n - base, busy);
    else n_pass++;
    n_checks++;
    if ({rd_data, err, gnt_id, mem_addr, mem_din, mem_rd, mem_wr} !== '0)
      $display("FAIL midrst_outputs: rd_data=%h err=%b gnt=%0d addr=%h, expected all 0", rd_data, err, gnt_id, mem_addr);
    else n_pass++;
    mem_auto = 1'b1;
  endtask

  task automatic test_priority();
    int base = obs_n;
    bit to;
    exp_t e;
    ext_addr = 12'h301; ext_we = 1'b0;
    ls_addr  = 12'h202; ls_we  = 1'b0;
    if_addr  = 12'h103;
    ext_req = 1'b1; ls_req = 1'b1; if_req = 1'b1;
    sb.push_back('{id: 2'd3, data: 16'hE0E0, err: 1'b0});
    sb.push_back('{id: 2'd2, data: 16'h5A02, err: 1'b0});
    sb.push_back('{id: 2'd1, data: 16'h1F03, err: 1'b0});
    serve(60, 1, to);
    n_checks++;
    if (to || (obs_n - base) != 3) $display("FAIL prio_count: timeout=%0d acks=%0d, expected 0/3", to, obs_n - base);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      n_checks++;
      if (obs_id[base+i] !== e.id || obs_gnt[base+i] !== e.id || obs_data[base+i] !== e.data || obs_err[base+i] !== e.err)
        $display("FAIL prio_ack%0d: id=%0d gnt=%0d data=%h err=%b, expected id=%0d data=%h err=%b", i,
                 obs_id[base+i], obs_gnt[base+i], obs_data[base+i], obs_err[base+i], e.id, e.data, e.err);
      else n_pass++;
    end
    n_checks++;
    if (obs_cyc[base+1] - obs_cyc[base] != 4 || obs_cyc[base+2] - obs_cyc[base+1] != 4)
      $display("FAIL prio_spacing: got %0d and %0d, expected 4 and 4",
               obs_cyc[base+1] - obs_cyc[base], obs_cyc[base+2] - obs_cyc[base+1]);
    else n_pass++;
  endtask

  task automatic test_ls_streak();
    int base = obs_n;
    bit to;
    exp_t e;
    ls_addr = 12'h050; ls_we = 1'b0;
    if_addr = 12'h060;
    ls_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{id: 2'd2, data: 16'h0A50, err: 1'b0});
    sb.push_back('{id: 2'd1, data: 16'h0B60, err: 1'b0});
    sb.push_back('{id: 2'd2, data: 16'h0A50, err: 1'b0});
    serve(100, 5, to);
    n_checks++;
    if (to || (obs_n - base) != 6) $display("FAIL streak_count: timeout=%0d acks=%0d, expected 0/6", to, obs_n - base);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front();
      n_checks++;
      if (obs_id[base+i] !== e.id || obs_gnt[base+i] !== e.id || obs_data[base+i] !== e.data || obs_err[base+i] !== e.err)
        $display("FAIL streak_ack%0d: id=%0d gnt=%0d data=%h err=%b, expected id=%0d data=%h err=%b", i,
                 obs_id[base+i], obs_gnt[base+i], obs_data[base+i], obs_err[base+i], e.id, e.data, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int base = obs_n;
    int t0;
    bit to;
    exp_t e;
    mem_auto = 1'b0;
    t0 = cyc;
    ls_addr = 12'h077; ls_we = 1'b0;
    ls_req  = 1'b1;
    sb.push_back('{id: 2'd2, data: 16'h0000, err: 1'b1});
    serve(150, 1, to);
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (to || (obs_n - base) != 1 || busy !== 1'b0)
      $display("FAIL tmo_count: timeout=%0d acks=%0d busy=%b, expected 0/1/0", to, obs_n - base, busy);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (obs_id[base] !== e.id || obs_data[base] !== e.data || obs_err[base] !== e.err)
      $display("FAIL tmo_ack: id=%0d data=%h err=%b, expected id=%0d data=%h err=%b",
               obs_id[base], obs_data[base], obs_err[base], e.id, e.data, e.err);
    else n_pass++;
    n_checks++;
    if (obs_cyc[base] - t0 != 66) $display("FAIL tmo_latency: got %0d cycles, expected 66", obs_cyc[base] - t0);
    else n_pass++;
    mem_auto = 1'b1;
    ls_addr  = 12'h078;
    ls_req   = 1'b1;
    sb.push_back('{id: 2'd2, data: 16'h7878, err: 1'b0});
    serve(30, 1, to);
    e = sb.pop_front();
    n_checks++;
    if (to || (obs_n - base) != 2 || obs_id[base+1] !== e.id || obs_data[base+1] !== e.data || obs_err[base+1] !== e.err)
      $display("FAIL tmo_next: acks=%0d id=%0d data=%h err=%b, expected 2 acks id=%0d data=%h err=%b",
               obs_n - base, obs_id[base+1], obs_data[base+1], obs_err[base+1], e.id, e.data, e.err);
    else n_pass++;
  endtask

  task automatic test_ext_write();
    int base = obs_n;
    int wb = wr_n;
    int rb = rd_n;
    bit to;
    exp_t e;
    ext_addr  = 12'hFFF;
    ext_wdata = 16'h1234;
    ext_we    = 1'b1;
    ext_req   = 1'b1;
    sb.push_back('{id: 2'd3, data: 16'h0000, err: 1'b0});
    serve(30, 1, to);
    n_checks++;
    if (to || (wr_n - wb) != 1 || (rd_n - rb) != 0)
      $display("FAIL wr_strobe: timeout=%0d wr_cycles=%0d rd_cycles=%0d, expected 0/1/0", to, wr_n - wb, rd_n - rb);
    else n_pass++;
    n_checks++;
    if (wr_addr !== 12'hFFF || wr_din !== 16'h1234)
      $display("FAIL wr_payload: addr=%h din=%h, expected fff/1234", wr_addr, wr_din);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ((obs_n - base) != 1 || obs_id[base] !== e.id || obs_data[base] !== e.data || obs_err[base] !== e.err)
      $display("FAIL wr_ack: acks=%0d id=%0d data=%h err=%b, expected 1 ack id=%0d data=%h err=%b",
               obs_n - base, obs_id[base], obs_data[base], obs_err[base], e.id, e.data, e.err);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) marr[i] = 16'(i) ^ 16'hA5A5;
    marr[12'h040] = 16'hBEEF;
    marr[12'h301] = 16'hE0E0;
    marr[12'h202] = 16'h5A02;
    marr[12'h103] = 16'h1F03;
    marr[12'h050] = 16'h0A50;
    marr[12'h060] = 16'h0B60;
    marr[12'h078] = 16'h7878;
    rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ext_req = 1'b0;
    ls_we = 1'b0; ext_we = 1'b0;
    if_addr = '0; ls_addr = '0; ext_addr = '0;
    ls_wdata = '0; ext_wdata = '0;
    man_valid = 1'b0;
    mem_auto  = 1'b1;

    test_reset();
    test_single_read();
    test_reset_mid_wait();
    test_priority();
    test_ls_streak();
    test_timeout();
    test_ext_write();

    n_checks++;
    if (obs_multi != 0 || sb.size() != 0)
      $display("FAIL final_state: multi_ack_cycles=%0d left_in_scoreboard=%0d, expected 0/0", obs_multi, sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
